// File: rtl/sys_reset_pkg.sv
// Shared types and helpers for the board reset/button/halt controller.
package sys_reset_pkg;

  typedef enum logic [2:0] {
    HOLD,
    COUNT,
    STAGE,
    RUN,
    HALTED
  } state_t;

  // Width of a counter that must hold values 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sys_reset_ctrl_btn_debounce.sv
// One button channel: synchroniser, debounce counter, level and press pulse.
module btn_debounce
  import sys_reset_pkg::*;
#(
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n,
  output logic level,
  output logic press
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], ~raw_n};
      press <= 1'b0;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == C_LAST) begin
        // Flip and pulse on the same edge; releases never pulse.
        cnt   <= '0;
        level <= ~level;
        press <= ~level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sys_reset_ctrl.sv
// Board reset controller: debounced buttons, lock gating, staged reset
// release and CPU run/halt enable.
module sys_reset_ctrl
  import sys_reset_pkg::*;
#(
  parameter int NUM_BUTTONS        = 2,
  parameter int SYNC_STAGES        = 3,
  parameter int DEBOUNCE_CYCLES    = 270000,
  parameter int RESET_DELAY_CYCLES = 16,
  parameter int NUM_STAGES         = 2,
  parameter int STAGE_GAP_CYCLES   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] button_n,
  input  logic                   lock_in,
  input  logic                   exit_in,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_STAGES-1:0]  reset_out,
  output logic                   cpu_enable,
  output logic                   halted
);

  localparam int DW = cnt_w(RESET_DELAY_CYCLES);
  localparam int GW = cnt_w(STAGE_GAP_CYCLES);
  localparam int SW = cnt_w(NUM_STAGES);
  localparam logic [DW-1:0] D_LAST = DW'(RESET_DELAY_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST = GW'(STAGE_GAP_CYCLES - 1);
  localparam logic [SW-1:0] S_LAST = SW'(NUM_STAGES - 1);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clock(clock),
      .reset(reset),
      .raw_n(button_n[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

  logic [SYNC_STAGES-1:0] lock_q;
  logic                   lock_sync;
  logic                   hold_req;

  assign lock_sync = lock_q[SYNC_STAGES-1];
  assign hold_req  = btn_level[0] | ~lock_sync;

  state_t                state, state_d;
  logic [DW-1:0]         dcnt, dcnt_d;
  logic [GW-1:0]         gcnt, gcnt_d;
  logic [SW-1:0]         sidx, sidx_d;
  logic [NUM_STAGES-1:0] ro_d;
  logic                  cpu_d;
  logic                  halt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_q     <= '0;
      state      <= HOLD;
      dcnt       <= '0;
      gcnt       <= '0;
      sidx       <= '0;
      reset_out  <= '1;
      cpu_enable <= 1'b0;
      halted     <= 1'b0;
    end else begin
      lock_q     <= {lock_q[SYNC_STAGES-2:0], lock_in};
      state      <= state_d;
      dcnt       <= dcnt_d;
      gcnt       <= gcnt_d;
      sidx       <= sidx_d;
      reset_out  <= ro_d;
      cpu_enable <= cpu_d;
      halted     <= halt_d;
    end
  end

  always_comb begin
    state_d = state;
    dcnt_d  = dcnt;
    gcnt_d  = gcnt;
    sidx_d  = sidx;
    ro_d    = reset_out;
    cpu_d   = cpu_enable;
    halt_d  = halted;
    if (state != HOLD && hold_req) begin
      // Abort outranks everything, including a coincident exit request.
      state_d = HOLD;
      dcnt_d  = '0;
      gcnt_d  = '0;
      sidx_d  = '0;
      ro_d    = '1;
      cpu_d   = 1'b0;
      halt_d  = 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          ro_d   = '1;
          cpu_d  = 1'b0;
          halt_d = 1'b0;
          if (!hold_req) begin
            state_d = COUNT;
            dcnt_d  = '0;
          end
        end
        COUNT: begin
          dcnt_d = dcnt + DW'(1);
          if (dcnt == D_LAST) begin
            dcnt_d = '0;
            gcnt_d = '0;
            sidx_d = SW'(1);
            if (NUM_STAGES == 1) begin
              state_d = RUN;
              ro_d    = '0;
              cpu_d   = 1'b1;
            end else begin
              state_d = STAGE;
              ro_d[0] = 1'b0;
            end
          end
        end
        STAGE: begin
          gcnt_d = gcnt + GW'(1);
          if (gcnt == G_LAST) begin
            gcnt_d = '0;
            sidx_d = sidx + SW'(1);
            for (int k = 0; k < NUM_STAGES; k++) begin
              if (SW'(k) == sidx) ro_d[k] = 1'b0;
            end
            if (sidx == S_LAST) begin
              state_d = RUN;
              ro_d    = '0;
              cpu_d   = 1'b1;
            end
          end
        end
        RUN: begin
          ro_d  = '0;
          cpu_d = 1'b1;
          if (exit_in) begin
            state_d = HALTED;
            cpu_d   = 1'b0;
            halt_d  = 1'b1;
          end
        end
        HALTED: begin
          if (btn_press[0]) begin
            state_d = HOLD;
            ro_d    = '1;
            cpu_d   = 1'b0;
            halt_d  = 1'b0;
          end
        end
        default: state_d = HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_reset_ctrl.sv
// Directed bench for sys_reset_ctrl with small timing parameters.
module tb_sys_reset_ctrl;

  logic       clock;
  logic       reset;
  logic [1:0] button_n;
  logic       lock_in;
  logic       exit_in;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [2:0] reset_out;
  logic       cpu_enable;
  logic       halted;

  int checks = 0;
  int errors = 0;

  sys_reset_ctrl #(
    .NUM_BUTTONS       (2),
    .SYNC_STAGES       (2),
    .DEBOUNCE_CYCLES   (4),
    .RESET_DELAY_CYCLES(8),
    .NUM_STAGES        (3),
    .STAGE_GAP_CYCLES  (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .button_n  (button_n),
    .lock_in   (lock_in),
    .exit_in   (exit_in),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .reset_out (reset_out),
    .cpu_enable(cpu_enable),
    .halted    (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ro"}, 32'(reset_out), 32'(3'b111));
    chk({tag, "_cpu"}, 32'(cpu_enable), 32'(0));
    chk({tag, "_halt"}, 32'(halted), 32'(0));
    chk({tag, "_lvl"}, 32'(btn_level), 32'(0));
    chk({tag, "_press"}, 32'(btn_press), 32'(0));
  endtask

  // reset_out[0] falls at edge 'base', then one stage every 2 edges.
  task automatic seq_chk(input string tag, input int base, input int len);
    logic [2:0] ro;
    for (int n = 1; n <= len; n++) begin
      tick();
      if (n < base) ro = 3'b111;
      else if (n < base + 2) ro = 3'b110;
      else if (n < base + 4) ro = 3'b100;
      else ro = 3'b000;
      chk($sformatf("%s_ro_e%0d", tag, n), 32'(reset_out), 32'(ro));
      chk($sformatf("%s_cpu_e%0d", tag, n), 32'(cpu_enable),
          32'(n >= base + 4));
    end
  endtask

  task automatic btn0_cycle(input string tag, input logic pre_halt);
    button_n[0] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 5) chk({tag, "_lvl0_e5"}, 32'(btn_level[0]), 32'(0));
      if (i == 6) begin
        chk({tag, "_lvl0_e6"}, 32'(btn_level[0]), 32'(1));
        chk({tag, "_press0_e6"}, 32'(btn_press[0]), 32'(1));
        chk({tag, "_ro_e6"}, 32'(reset_out), 32'(0));
        chk({tag, "_halt_e6"}, 32'(halted), 32'(pre_halt));
      end
      if (i == 7) begin
        chk({tag, "_press0_e7"}, 32'(btn_press[0]), 32'(0));
        chk({tag, "_ro_e7"}, 32'(reset_out), 32'(3'b111));
        chk({tag, "_cpu_e7"}, 32'(cpu_enable), 32'(0));
        chk({tag, "_halt_e7"}, 32'(halted), 32'(0));
      end
    end
    button_n[0] = 1'b1;
    seq_chk({tag, "_restart"}, 15, 20);
  endtask

  initial begin
    reset    = 1'b1;
    button_n = 2'b11;
    lock_in  = 1'b1;
    exit_in  = 1'b0;
    #3;
    chk_reset_vals("por");
    #9;
    reset = 1'b0;
    seq_chk("pwrup", 11, 16);

    // Short glitch on button 1 must be filtered.
    button_n[1] = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    button_n[1] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("glitch_lvl_e%0d", i), 32'(btn_level[1]), 32'(0));
      chk($sformatf("glitch_press_e%0d", i), 32'(btn_press[1]), 32'(0));
    end

    // Clean 10-cycle press on button 1.
    button_n[1] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("b1_lvl_e%0d", i), 32'(btn_level[1]), 32'(i >= 6));
      chk($sformatf("b1_press_e%0d", i), 32'(btn_press[1]), 32'(i == 6));
      chk($sformatf("b1_ro_e%0d", i), 32'(reset_out), 32'(0));
      chk($sformatf("b1_cpu_e%0d", i), 32'(cpu_enable), 32'(1));
    end
    button_n[1] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("b1rel_lvl_e%0d", i), 32'(btn_level[1]), 32'(i < 6));
      chk($sformatf("b1rel_press_e%0d", i), 32'(btn_press[1]), 32'(0));
    end

    btn0_cycle("rstbtn", 1'b0);

    // Halt on a one-cycle exit pulse.
    exit_in = 1'b1;
    tick();
    exit_in = 1'b0;
    chk("halt_halted", 32'(halted), 32'(1));
    chk("halt_cpu", 32'(cpu_enable), 32'(0));
    chk("halt_ro", 32'(reset_out), 32'(0));
    for (int i = 1; i <= 100; i++) begin
      exit_in = (i < 20);
      tick();
      chk($sformatf("halt_hold_e%0d", i), 32'(halted), 32'(1));
      chk($sformatf("halt_ro_e%0d", i), 32'(reset_out), 32'(0));
    end
    exit_in = 1'b0;
    btn0_cycle("unhalt", 1'b1);

    // Lock loss coinciding with exit at the state machine.
    lock_in = 1'b0;
    tick();
    tick();
    chk("lx_cpu_pre", 32'(cpu_enable), 32'(1));
    exit_in = 1'b1;
    tick();
    exit_in = 1'b0;
    chk("lx_halt", 32'(halted), 32'(0));
    chk("lx_ro", 32'(reset_out), 32'(3'b111));
    chk("lx_cpu", 32'(cpu_enable), 32'(0));
    for (int i = 0; i < 3; i++) tick();
    chk("lx_stay_halt", 32'(halted), 32'(0));
    chk("lx_stay_ro", 32'(reset_out), 32'(3'b111));

    // Relock, then lose lock again mid-STAGE.
    lock_in = 1'b1;
    seq_chk("relock", 11, 12);
    lock_in = 1'b0;
    tick();
    chk("ll_ro_e1", 32'(reset_out), 32'(3'b100));
    tick();
    tick();
    chk("ll_ro_e3", 32'(reset_out), 32'(3'b111));
    chk("ll_cpu_e3", 32'(cpu_enable), 32'(0));

    // Async reset mid-COUNT, between edges.
    lock_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("arst_count");
    #2;
    reset = 1'b0;
    seq_chk("arst_restart", 11, 16);

    // Async reset from RUN must take effect without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("arst_run");
    #2;
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sys_reset_ctrl.md
Name: sys_reset_ctrl

Overview:
Parametrised board-level reset, button and halt controller. It replaces the fixed 3-flop button synchroniser, the single reset_seq and the ad-hoc halt flop in the board top. It synchronises and debounces N active-low buttons and gates everything on PLL lock. It releases an ordered set of reset stages with programmable gaps, and it holds a CPU-run enable that drops on an exit request. Button 0 is the system reset button.

Parameters:
NUM_BUTTONS, 2, number of raw button inputs (>=1); index 0 is the reset button
SYNC_STAGES, 3, synchroniser flops per button and for lock_in (>=2)
DEBOUNCE_CYCLES, 270000, consecutive stable cycles required to change a debounced level (>=1)
RESET_DELAY_CYCLES, 16, cycles from leaving HOLD to release of reset_out[0] (>=1)
NUM_STAGES, 2, number of ordered reset outputs (>=1)
STAGE_GAP_CYCLES, 4, cycles between releases of consecutive stages (>=1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high; forces every register to its reset value
button_n  in  NUM_BUTTONS  raw active-low buttons, asynchronous to clock
lock_in  in  1  PLL lock, asynchronous to clock
exit_in  in  1  CPU exit request, synchronous to clock, level
btn_level  out  NUM_BUTTONS  debounced pressed level, 1 = pressed
btn_press  out  NUM_BUTTONS  one-cycle pulse on each debounced press edge
reset_out  out  NUM_STAGES  active-high stage resets; stage 0 is released first
cpu_enable  out  1  1 = CPU may run; used as a clock-enable, never as a gated clock
halted  out  1  1 while in HALTED

Behaviour:
- Reset values: btn_level=0, btn_press=0, reset_out=all 1, cpu_enable=0, halted=0, state=HOLD.
- Synchronisers: each button is inverted, then passed through SYNC_STAGES flops that reset to 0 (not pressed). lock_in passes through SYNC_STAGES flops that reset to 0.
- Debounce, per channel:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - When the synced value differs from btn_level, the counter increments. When the two are equal, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, btn_level flips and the counter clears.
  - For a clean raw edge, btn_level changes SYNC_STAGES+DEBOUNCE_CYCLES clock edges after the raw change. A glitch shorter than DEBOUNCE_CYCLES cycles never reaches btn_level.
  - btn_press is high for exactly the one cycle after btn_level goes 0->1. A release produces no pulse.
- The abort condition is hold_req = btn_level[0] | ~lock_sync.
- HOLD:
  - All reset_out=1, cpu_enable=0.
  - When hold_req=0, go to COUNT and load the counter with 0.
- COUNT:
  - All reset_out=1. The counter increments every cycle.
  - On the cycle the counter equals RESET_DELAY_CYCLES-1, go to STAGE: reset_out[0] becomes 0 on the next edge, and the stage counter clears.
  - reset_out[0] therefore falls RESET_DELAY_CYCLES edges after entering COUNT.
- STAGE:
  - reset_out[k] falls k*STAGE_GAP_CYCLES edges after reset_out[0] falls. Released stages stay 0.
  - The edge that releases reset_out[NUM_STAGES-1] also enters RUN and sets cpu_enable=1 on that same edge.
  - With NUM_STAGES=1, COUNT goes directly to RUN.
- RUN:
  - reset_out=all 0, cpu_enable=1.
  - exit_in=1 moves to HALTED: cpu_enable=0 and halted=1 on the next edge, while reset_out stays 0.
- HALTED:
  - Stays here regardless of exit_in.
  - btn_press[0] exits the halt through HOLD.
- Abort: in COUNT, STAGE, RUN or HALTED, hold_req=1 moves to HOLD on the next edge. That edge reasserts all reset_out, clears cpu_enable and halted, and discards all counters.
- Priority when events coincide: hold_req, then exit_in. Lock loss together with exit_in goes to HOLD, not HALTED.
- Asynchronous reset mid-sequence returns immediately to the reset values above. The sequence restarts from HOLD after reset deasserts.
- Buttons 1..NUM_BUTTONS-1 only drive btn_level and btn_press; they never affect the state machine.

Decomposition:
- Package sys_reset_pkg:
  - typedef enum logic [2:0] state_t {HOLD, COUNT, STAGE, RUN, HALTED}
  - localparam function clog2-based counter width helper
- Sub-module btn_debounce holds the synchroniser, counter, level and press-pulse logic for one channel, parametrised by SYNC_STAGES and DEBOUNCE_CYCLES. It is instantiated NUM_BUTTONS times with a generate loop.
- lock_in uses the synchroniser only, as an inline flop chain.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_DELAY_CYCLES=8, NUM_STAGES=3, STAGE_GAP_CYCLES=2, NUM_BUTTONS=2.
- Power-up sequence: lock_in=1, buttons high, reset deasserted -> after lock sync, reset_out[0] falls 8 edges after entering COUNT; reset_out[1] falls 2 edges later and reset_out[2] 4 edges later; cpu_enable rises with reset_out[2].
- Debounce: button_n[1] low pulse of 3 cycles -> btn_level[1] stays 0 and no btn_press. A low hold of 10 cycles -> btn_level[1]=1 exactly 6 edges after the fall, with btn_press[1] high for 1 cycle, and state unchanged.
- Reset button: in RUN, hold button_n[0] low for 10 cycles, then release -> all reset_out=1 and cpu_enable=0 one edge after btn_level[0] rises. The full 8+2+2 release sequence restarts after btn_level[0] falls.
- Halt: in RUN, pulse exit_in for 1 cycle -> halted=1 and cpu_enable=0 on the next edge; reset_out stays 0 and the state holds for 100 cycles. A button 0 press -> HOLD, then the restart sequence.
- Lock loss: drop lock_in during STAGE after reset_out[0] has fallen -> all reset_out=1 within SYNC_STAGES+1 edges. lock_in together with exit_in in RUN -> HOLD, halted=0.
- Asynchronous reset: assert reset mid-COUNT, between clock edges -> outputs reach reset values without a clock edge, and the sequence restarts cleanly after deassertion.
